// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package fifo_pkg;

    localparam bit FIFO_MODE_STD  = 1'b0;
    localparam bit FIFO_MODE_FWFT = 1'b1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with registered read port for block RAM inference.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO control: pointers, level, flags, errors and FWFT prefetch.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int LW    = ADDR_WIDTH + 1;
    localparam bit IS_FWFT = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_THRESH);

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_ctrl: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_ctrl: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo_ctrl: FWFT must be 0 or 1");
    end

    logic [LW-1:0]         wptr;
    logic [LW-1:0]         rptr;
    logic [LW-1:0]         level_n;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  re;
    logic                  rvalid_n;
    logic                  ufl;
    logic                  data_ok;
    logic [DATA_WIDTH-1:0] ram_q;

    // In FWFT mode the RAM output register doubles as the head register:
    // it is refilled whenever it is empty or being popped this cycle.
    always_comb begin
        wr_acc   = wr_en && !full && !flush;
        rd_acc   = 1'b0;
        re       = 1'b0;
        rvalid_n = 1'b0;
        ufl      = 1'b0;
        if (IS_FWFT) begin
            rd_acc   = rd_en && rvalid && !flush;
            re       = !flush && (wptr != rptr) && (!rvalid || rd_acc);
            rvalid_n = !flush && (re || (rvalid && !rd_acc));
            ufl      = rd_en && !rvalid && !flush;
        end else begin
            rd_acc   = rd_en && (level != '0) && !flush;
            re       = rd_acc;
            rvalid_n = rd_acc;
            ufl      = rd_en && (level == '0) && !flush;
        end
        level_n = level + LW'(wr_acc) - LW'(rd_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            empty        <= 1'b1;
            rvalid       <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            data_ok      <= 1'b0;
        end else if (flush) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            empty        <= 1'b1;
            rvalid       <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (re) begin
                rptr    <= rptr + 1'b1;
                data_ok <= 1'b1;
            end
            level        <= level_n;
            full         <= (level_n == DEPTH_L);
            almost_full  <= (level_n >= AF_L);
            almost_empty <= (level_n <= AE_L);
            empty        <= IS_FWFT ? !rvalid_n : (level_n == '0);
            rvalid       <= rvalid_n;
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (ufl) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wptr[ADDR_WIDTH-1:0]),
        .wdata(wdata),
        .re   (re),
        .raddr(rptr[ADDR_WIDTH-1:0]),
        .rdata(ram_q)
    );

    // The RAM output register has no reset, so hide it until first loaded.
    assign rdata = data_ok ? ram_q : '0;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl in standard and FWFT read modes.
module tb_sync_fifo_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s_flush, s_wr, s_rd, s_full, s_af, s_rvalid, s_empty, s_ae;
    logic        s_ovf, s_udf;
    logic [15:0] s_wdata, s_rdata;
    logic [8:0]  s_level;

    logic        f_flush, f_wr, f_rd, f_full, f_af, f_rvalid, f_empty, f_ae;
    logic        f_ovf, f_udf;
    logic [15:0] f_wdata, f_rdata;
    logic [8:0]  f_level;

    int passed = 0;
    int total  = 0;

    sync_fifo_ctrl #(.FWFT(0)) dut_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .wr_en(s_wr), .wdata(s_wdata), .full(s_full), .almost_full(s_af),
        .rd_en(s_rd), .rdata(s_rdata), .rvalid(s_rvalid), .empty(s_empty),
        .almost_empty(s_ae), .level(s_level),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_ctrl #(.FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush),
        .wr_en(f_wr), .wdata(f_wdata), .full(f_full), .almost_full(f_af),
        .rd_en(f_rd), .rdata(f_rdata), .rvalid(f_rvalid), .empty(f_empty),
        .almost_empty(f_ae), .level(f_level),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {s_flush, s_wr, s_rd, f_flush, f_wr, f_rd} = '0;
        s_wdata = '0;
        f_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_level", 32'(s_level), 0);
        check("rst_s_empty", 32'(s_empty), 1);
        check("rst_s_ae", 32'(s_ae), 1);
        check("rst_s_full", 32'(s_full), 0);
        check("rst_s_af", 32'(s_af), 0);
        check("rst_s_rvalid", 32'(s_rvalid), 0);
        check("rst_s_rdata", 32'(s_rdata), 0);
        check("rst_s_errs", 32'({s_ovf, s_udf}), 0);
        check("rst_f_empty", 32'(f_empty), 1);
        check("rst_f_rvalid", 32'(f_rvalid), 0);
        rst_n = 1'b1;
        tick();

        // FWFT: write to empty at cycle N, head visible at N+2
        f_wr = 1'b1;
        f_wdata = 16'hABCD;
        tick();
        f_wr = 1'b0;
        check("fwft_n1_rvalid", 32'(f_rvalid), 0);
        check("fwft_n1_level", 32'(f_level), 1);
        tick();
        check("fwft_n2_rvalid", 32'(f_rvalid), 1);
        check("fwft_n2_rdata", 32'(f_rdata), 32'hABCD);
        check("fwft_n2_empty", 32'(f_empty), 0);
        for (int i = 1; i <= 4; i++) begin
            f_wr = 1'b1;
            f_wdata = 16'(16'h100 + i);
            tick();
        end
        check("fwft_pre_level", 32'(f_level), 5);
        check("fwft_pre_head", 32'(f_rdata), 32'hABCD);
        for (int k = 0; k < 20; k++) begin
            f_wr = 1'b1;
            f_rd = 1'b1;
            f_wdata = 16'(16'h105 + k);
            tick();
            check("fwft_stream_rvalid", 32'(f_rvalid), 1);
            check("fwft_stream_rdata", 32'(f_rdata), 32'(16'h101 + k));
            check("fwft_stream_level", 32'(f_level), 5);
        end
        f_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fwft_drain_rdata", 32'(f_rdata), 32'(16'h115 + k));
        end
        tick();
        check("fwft_drained_rvalid", 32'(f_rvalid), 0);
        check("fwft_drained_empty", 32'(f_empty), 1);
        check("fwft_drained_level", 32'(f_level), 0);
        check("fwft_no_udf_yet", 32'(f_udf), 0);
        tick();
        f_rd = 1'b0;
        check("fwft_udf", 32'(f_udf), 1);

        // Standard: fill to full
        for (int i = 1; i <= 256; i++) begin
            s_wr = 1'b1;
            s_wdata = 16'(i);
            tick();
            if (i == 4)   check("std_ae_at4", 32'(s_ae), 1);
            if (i == 5)   check("std_ae_at5", 32'(s_ae), 0);
            if (i == 251) check("std_af_at251", 32'(s_af), 0);
            if (i == 252) check("std_af_at252", 32'(s_af), 1);
            if (i == 255) check("std_full_at255", 32'(s_full), 0);
        end
        check("std_full", 32'(s_full), 1);
        check("std_full_level", 32'(s_level), 256);
        check("std_no_ovf_yet", 32'(s_ovf), 0);
        s_wdata = 16'h0999;
        tick();
        s_wr = 1'b0;
        check("std_ovf", 32'(s_ovf), 1);
        check("std_ovf_level", 32'(s_level), 256);

        // Standard: drain, data one cycle after rd_en
        for (int i = 1; i <= 256; i++) begin
            s_rd = 1'b1;
            tick();
            check("std_rd_rvalid", 32'(s_rvalid), 1);
            check("std_rd_rdata", 32'(s_rdata), 32'(i));
        end
        check("std_drained_empty", 32'(s_empty), 1);
        check("std_drained_level", 32'(s_level), 0);
        check("std_no_udf_yet", 32'(s_udf), 0);
        tick();
        s_rd = 1'b0;
        check("std_udf", 32'(s_udf), 1);
        check("std_udf_rvalid", 32'(s_rvalid), 0);
        check("std_rdata_hold", 32'(s_rdata), 32'h0100);

        // Flush at level 50 with overflow set, alongside wr/rd
        for (int i = 0; i < 50; i++) begin
            s_wr = 1'b1;
            s_wdata = 16'(16'h0300 + i);
            tick();
        end
        check("std_l50", 32'(s_level), 50);
        check("std_l50_ovf", 32'(s_ovf), 1);
        s_flush = 1'b1;
        s_rd = 1'b1;
        s_wdata = 16'hDEAD;
        tick();
        {s_flush, s_wr, s_rd} = '0;
        check("flush_level", 32'(s_level), 0);
        check("flush_empty", 32'(s_empty), 1);
        check("flush_errs", 32'({s_ovf, s_udf}), 0);
        check("flush_rvalid", 32'(s_rvalid), 0);
        s_wr = 1'b1;
        s_wdata = 16'h1234;
        tick();
        s_wr = 1'b0;
        check("post_flush_level", 32'(s_level), 1);
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        check("post_flush_rdata", 32'(s_rdata), 32'h1234);
        check("post_flush_empty", 32'(s_empty), 1);

        // Fill to 100 then 1000 cycles of simultaneous write and read
        for (int i = 1; i <= 100; i++) begin
            s_wr = 1'b1;
            s_wdata = 16'(16'h2000 + i);
            tick();
        end
        check("fill100_level", 32'(s_level), 100);
        for (int k = 0; k < 1000; k++) begin
            s_wr = 1'b1;
            s_rd = 1'b1;
            s_wdata = 16'(16'h2000 + 101 + k);
            tick();
            check("wrap_rdata", 32'(s_rdata), 32'(16'h2000 + 1 + k));
            check("wrap_level", 32'(s_level), 100);
        end
        s_rd = 1'b0;
        s_wdata = 16'hBEEF;
        tick();
        tick();

        // Asynchronous reset mid-burst, no clock edge in between
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_level", 32'(s_level), 0);
        check("arst_empty", 32'(s_empty), 1);
        check("arst_full_af", 32'({s_full, s_af}), 0);
        check("arst_rdata", 32'(s_rdata), 0);
        check("arst_rvalid", 32'(s_rvalid), 0);
        check("arst_errs", 32'({s_ovf, s_udf}), 0);
        check("arst_ae", 32'(s_ae), 1);
        s_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        s_wr = 1'b1;
        s_wdata = 16'h5A5A;
        tick();
        s_wr = 1'b0;
        check("arst_rt_level", 32'(s_level), 1);
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        check("arst_rt_rvalid", 32'(s_rvalid), 1);
        check("arst_rt_rdata", 32'(s_rdata), 32'h5A5A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
